muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit sitting directly upstream of the register bank write port.
- Consumes the two register-read operands plus funct3 and destination index.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Presents result, destination index and a one-cycle write-enable pulse for the register bank's synchronous write.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit feeding the register bank
//            write port. Optional macro FAST_MUL_EN: single-edge multiplies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic            abort,
   input  logic [2:0]      funct3,
   input  logic [4:0]      rdIn,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   output logic            busy,
   output logic            done,
   output logic            writeRegister,
   output logic [4:0]      rdOut,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state;
   logic [CW-1:0]     counter;
   logic [2:0]        op;
   logic [4:0]        rd;
   logic              neg;
   logic              rem_neg;
   logic [XLEN-1:0]   addend;
   logic [2*XLEN-1:0] acc;

   logic              a_signed_in, b_signed_in, sign_a_in, sign_b_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   special_res;

   // Operand decode at accept: magnitudes plus result/remainder sign.
   always_comb begin
      a_signed_in = (funct3 != 3'b011) && !(funct3[2] && funct3[0]);
      b_signed_in = a_signed_in && (funct3 != 3'b010);
      sign_a_in   = a_signed_in && operandA[XLEN-1];
      sign_b_in   = b_signed_in && operandB[XLEN-1];
      mag_a_in    = sign_a_in ? -operandA : operandA;
      mag_b_in    = sign_b_in ? -operandB : operandB;
      div_zero    = funct3[2] && (operandB == '0);
      div_ovf     = funct3[2] && !funct3[0] && (operandA == MIN_INT) && (operandB == '1);
      special_res = '0;
      if (div_zero)
         special_res = funct3[1] ? operandA : '1;
      else if (div_ovf)
         special_res = funct3[1] ? '0 : operandA;
   end

   logic [XLEN-1:0]   mul_add;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_trial;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem;
   logic [XLEN-1:0]   final_res;

   // One shift-add or restoring-subtract step, then sign fix and word select.
   always_comb begin
      mul_add   = acc[0] ? addend : '0;
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
      div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, addend};
      if (!op[2])
         acc_next = {mul_sum, acc[XLEN-1:1]};
      else if (!div_trial[XLEN])
         acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_next = {acc[2*XLEN-2:XLEN], acc[XLEN-1], acc[XLEN-2:0], 1'b0};

      prod = neg ? -acc_next : acc_next;
      quot = acc_next[XLEN-1:0];
      rem  = acc_next[2*XLEN-1:XLEN];
      if (!op[2])
         final_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (op[1])
         final_res = rem_neg ? -rem : rem;
      else
         final_res = neg ? -quot : quot;
   end

`ifdef FAST_MUL_EN
   logic [2*XLEN-1:0] fast_mag, fast_prod;
   logic [XLEN-1:0]   fast_res;

   always_comb begin
      fast_mag  = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
      fast_prod = (sign_a_in ^ sign_b_in) ? -fast_mag : fast_mag;
      fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         counter       <= '0;
         op            <= '0;
         rd            <= '0;
         neg           <= 1'b0;
         rem_neg       <= 1'b0;
         addend        <= '0;
         acc           <= '0;
         done          <= 1'b0;
         writeRegister <= 1'b0;
         rdOut         <= '0;
         result        <= '0;
      end else begin
         done          <= 1'b0;
         writeRegister <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  op      <= funct3;
                  rd      <= rdIn;
                  neg     <= sign_a_in ^ sign_b_in;
                  rem_neg <= sign_a_in;
                  addend  <= funct3[2] ? mag_b_in : mag_a_in;
                  acc     <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_in : mag_b_in)};
                  if (div_zero || div_ovf) begin
                     result        <= special_res;
                     rdOut         <= rdIn;
                     done          <= 1'b1;
                     writeRegister <= (rdIn != 5'd0);
                     state         <= DONE;
                  end
`ifdef FAST_MUL_EN
                  else if (!funct3[2]) begin
                     result        <= fast_res;
                     rdOut         <= rdIn;
                     done          <= 1'b1;
                     writeRegister <= (rdIn != 5'd0);
                     state         <= DONE;
                  end
`endif
                  else begin
                     counter <= CW'(XLEN);
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  counter <= '0;
                  state   <= IDLE;
               end else begin
                  acc     <= acc_next;
                  counter <= counter - CW'(1);
                  if (counter == CW'(1)) begin
                     result        <= final_res;
                     rdOut         <= rd;
                     done          <= 1'b1;
                     writeRegister <= (rd != 5'd0);
                     state         <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [4:0]  rdIn = '0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        busy, done, writeRegister;
   logic [4:0]  rdOut;
   logic [31:0] result;

   muldiv_unit #(.XLEN(32)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .funct3(funct3), .rdIn(rdIn), .operandA(operandA), .operandB(operandB),
      .busy(busy), .done(done), .writeRegister(writeRegister),
      .rdOut(rdOut), .result(result)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] due;
   } exp_t;

   exp_t        exp_q[$];
   int          ncomp = 0;
   int          nfail = 0;
   logic        prev_done = 1'b0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_rd = '0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      ncomp++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // RV32M semantics in plain integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (f)
         3'b000: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
         3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
         3'b011: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef FAST_MUL_EN
      if (!f[2]) return 1;
`endif
      return 33;
   endfunction

   // Monitor: every completion pops one expectation.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && done) begin
         check("done_one_cycle", {31'd0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            ncomp++;
            nfail++;
            $display("FAIL unexpected_done: got completion result %h rd %0d, expected none", result, rdOut);
         end else begin
            e = exp_q.pop_front();
            check("result", result, e.res);
            check("rdOut", {27'd0, rdOut}, {27'd0, e.rd});
            check("writeRegister", {31'd0, writeRegister}, {31'd0, e.wr});
            check("latency_cycle", cyc, e.due);
         end
      end
      prev_done = done;
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit track, input logic [31:0] res);
      exp_t e;
      @(negedge clock);
      funct3 = f; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      if (track) begin
         e.res = res;
         e.rd  = rd;
         e.wr  = (rd != 0);
         e.due = cyc + latency(f, a, b) - 1;
         exp_q.push_back(e);
         last_res = res;
         last_rd  = rd;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (!busy) return;
      end
      ncomp++;
      nfail++;
      $display("FAIL idle_timeout: busy still %0b after 100 cycles, expected 0", busy);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
   } dir_t;

   dir_t dir_tab[14] = '{
      '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB},
      '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE},
      '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000},
      '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF},
      '{3'b100, -32'sd20,       32'd6,         5'd4,  32'hFFFF_FFFD},
      '{3'b110, -32'sd20,       32'd6,         5'd6,  32'hFFFF_FFFE},
      '{3'b101, 32'd100,        32'd7,         5'd7,  32'd14},
      '{3'b111, 32'd100,        32'd7,         5'd8,  32'd2},
      '{3'b101, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF},
      '{3'b110, 32'd5,          32'd0,         5'd10, 32'd5},
      '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
      '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0},
      '{3'b000, 32'd1234,       32'd5678,      5'd0,  32'd7006652},
      '{3'b100, 32'h8000_0000,  32'd1,         5'd31, 32'h8000_0000}
   };

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;

      #1;
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_done",   {31'd0, done}, 32'd0);
      check("reset_wr",     {31'd0, writeRegister}, 32'd0);
      check("reset_rdOut",  {27'd0, rdOut}, 32'd0);
      check("reset_result", result, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      foreach (dir_tab[i]) begin
         issue(dir_tab[i].f, dir_tab[i].a, dir_tab[i].b, dir_tab[i].rd, 1'b1, dir_tab[i].res);
         wait_idle();
      end

      // A second start while busy must be dropped.
      issue(3'b101, 32'd1000, 32'd7, 5'd3, 1'b1, 32'd142);
      repeat (10) @(negedge clock);
      funct3 = 3'b000; operandA = 32'd9; operandB = 32'd9; rdIn = 5'd4; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clock);

      // Abort mid-run: no completion, previous outputs retained.
      issue(3'b101, 32'd999, 32'd4, 5'd7, 1'b0, 32'd0);
      repeat (10) @(negedge clock);
      abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      @(negedge clock);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_result_held", result, last_res);
      check("abort_rd_held", {27'd0, rdOut}, {27'd0, last_rd});
      repeat (40) @(negedge clock);

      // Start and abort together in IDLE: abort wins.
      funct3 = 3'b000; operandA = 32'd3; operandB = 32'd3; rdIn = 5'd1;
      start = 1'b1; abort = 1'b1;
      @(posedge clock);
      #1 start = 1'b0; abort = 1'b0;
      @(negedge clock);
      check("start_abort_idle_busy", {31'd0, busy}, 32'd0);

      // Abort during DONE: the pulse still completes.
      issue(3'b111, 32'd77, 32'd0, 5'd20, 1'b1, 32'd77);
      abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      wait_idle();

      for (int n = 0; n < 40; n++) begin
         f  = 3'($urandom_range(0, 7));
         a  = $urandom();
         b  = $urandom();
         rd = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'd1;
            3: a = a >> $urandom_range(0, 31);
            4: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         issue(f, a, b, rd, 1'b1, model(f, a, b));
         wait_idle();
      end

      // Asynchronous reset mid-run clears everything immediately.
      issue(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 1'b0, 32'd0);
      repeat (10) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midreset_busy",   {31'd0, busy}, 32'd0);
      check("midreset_done",   {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_rdOut",  {27'd0, rdOut}, 32'd0);
      #2 reset_n = 1'b1;
      issue(3'b100, 32'd1000, -32'sd8, 5'd15, 1'b1, model(3'b100, 32'd1000, -32'sd8));
      wait_idle();

      repeat (3) @(negedge clock);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule

`default_nettype wire
